// File: rtl/copperv_lsu.sv
// copperv load/store unit: sized, lane-steered data bus accesses, one at a time.
// Optional wait-state watchdog is built when LSU_TIMEOUT_EN is defined.
module copperv_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    done_valid,
  output logic [1:0]              done_err,
  output logic [DATA_WIDTH-1:0]   done_rdata,
  output logic                    dr_addr_valid,
  input  logic                    dr_addr_ready,
  output logic [ADDR_WIDTH-1:0]   dr_addr,
  input  logic                    dr_data_valid,
  output logic                    dr_data_ready,
  input  logic [DATA_WIDTH-1:0]   dr_data,
  output logic                    dw_data_addr_valid,
  input  logic                    dw_data_addr_ready,
  output logic [ADDR_WIDTH-1:0]   dw_addr,
  output logic [DATA_WIDTH-1:0]   dw_data,
  output logic [DATA_WIDTH/8-1:0] dw_strobe,
  input  logic                    dw_resp_valid,
  output logic                    dw_resp_ready,
  input  logic [RESP_WIDTH-1:0]   dw_resp
);

  localparam int S  = DATA_WIDTH / 8;
  localparam int LW = $clog2(S);
  localparam logic [RESP_WIDTH-1:0] DATA_WRITE_RESP_OK = '0;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("copperv_lsu: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("copperv_lsu: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t state;
  state_t next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         lane_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic                  misal;
  logic                  tmo;
  logic [1:0]            err_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic                  ld_sign;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] wrep;
  logic [S-1:0]          nbytes;
  logic                  accept;

  assign req_ready          = (state == IDLE);
  assign accept             = req_ready && req_valid;
  assign dr_addr_valid      = (state == RD_ADDR);
  assign dr_data_ready      = (state == RD_DATA);
  assign dw_data_addr_valid = (state == WR_REQ);
  assign dw_resp_ready      = (state == WR_RESP);
  assign done_valid         = (state == DONE);
  assign dr_addr            = addr_q;
  assign dw_addr            = addr_q;

  always_comb begin
    misal = 1'b0;
    unique case (req_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      default: misal = (DATA_WIDTH != 64) || (|req_addr[2:0]);
    endcase
  end

  // Store data is replicated so every lane carries it; strobes pick the lane.
  always_comb begin
    wrep   = req_wdata;
    nbytes = '1;
    unique case (req_size)
      2'd0: begin
        wrep   = {S{req_wdata[7:0]}};
        nbytes = S'(1);
      end
      2'd1: begin
        wrep   = {(S/2){req_wdata[15:0]}};
        nbytes = S'(3);
      end
      2'd2: begin
        wrep   = {(S/4){req_wdata[31:0]}};
        nbytes = S'(15);
      end
      default: begin
        wrep   = req_wdata;
        nbytes = '1;
      end
    endcase
  end

  assign shifted = dr_data >> {lane_q, 3'b000};

  always_comb begin
    ld_mask = '1;
    ld_sign = 1'b0;
    unique case (size_q)
      2'd0: begin
        ld_mask = DATA_WIDTH'(8'hff);
        ld_sign = shifted[7];
      end
      2'd1: begin
        ld_mask = DATA_WIDTH'(16'hffff);
        ld_sign = shifted[15];
      end
      2'd2: begin
        ld_mask = DATA_WIDTH'(32'hffff_ffff);
        ld_sign = shifted[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = 1'b0;
      end
    endcase
    ld_ext = shifted & ld_mask;
    if (!uns_q && ld_sign) ld_ext = ld_ext | ~ld_mask;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          wait_st;

  assign wait_st = (state == RD_ADDR) || (state == RD_DATA)
                || (state == WR_REQ)  || (state == WR_RESP);

  always_ff @(posedge clk) begin
    if (!rst || next != state) cnt <= '0;
    else if (wait_st)          cnt <= cnt + CW'(1);
  end

  assign tmo = wait_st && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // A handshake seen in the timeout cycle takes priority over the timeout.
  always_comb begin
    next    = state;
    err_d   = 2'd0;
    rdata_d = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misal) begin
            next  = DONE;
            err_d = 2'd2;
          end else if (req_store) begin
            next = WR_REQ;
          end else begin
            next = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (dr_addr_ready) begin
          next = RD_DATA;
        end else if (tmo) begin
          next  = DONE;
          err_d = 2'd3;
        end
      end
      RD_DATA: begin
        if (dr_data_valid) begin
          next    = DONE;
          rdata_d = ld_ext;
        end else if (tmo) begin
          next  = DONE;
          err_d = 2'd3;
        end
      end
      WR_REQ: begin
        if (dw_data_addr_ready) begin
          next = WR_RESP;
        end else if (tmo) begin
          next  = DONE;
          err_d = 2'd3;
        end
      end
      WR_RESP: begin
        if (dw_resp_valid) begin
          next  = DONE;
          err_d = (dw_resp == DATA_WRITE_RESP_OK) ? 2'd0 : 2'd1;
        end else if (tmo) begin
          next  = DONE;
          err_d = 2'd3;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      dw_data    <= '0;
      dw_strobe  <= '0;
      done_err   <= '0;
      done_rdata <= '0;
    end else begin
      done_err   <= err_d;
      done_rdata <= rdata_d;
      if (accept) begin
        addr_q    <= {req_addr[ADDR_WIDTH-1:LW], LW'(0)};
        lane_q    <= req_addr[LW-1:0];
        size_q    <= req_size;
        uns_q     <= req_unsigned;
        dw_data   <= wrep;
        dw_strobe <= nbytes << req_addr[LW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_copperv_lsu.sv
// Bench for copperv_lsu: directed test-plan steps plus randomized accesses
// checked against a byte-level reference model.
module tb_copperv_lsu;

`ifdef LSU_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 4;
`endif
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done_valid;
  logic [1:0]  done_err;
  logic [31:0] done_rdata;
  logic        dr_addr_valid;
  logic        dr_addr_ready = 1'b0;
  logic [31:0] dr_addr;
  logic        dr_data_valid = 1'b0;
  logic        dr_data_ready;
  logic [31:0] dr_data = '0;
  logic        dw_data_addr_valid;
  logic        dw_data_addr_ready = 1'b0;
  logic [31:0] dw_addr;
  logic [31:0] dw_data;
  logic [3:0]  dw_strobe;
  logic        dw_resp_valid = 1'b0;
  logic        dw_resp_ready;
  logic [1:0]  dw_resp = '0;

  int checks = 0;
  int failures = 0;

  copperv_lsu #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESP_WIDTH(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_store(req_store),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .done_valid(done_valid),
    .done_err(done_err),
    .done_rdata(done_rdata),
    .dr_addr_valid(dr_addr_valid),
    .dr_addr_ready(dr_addr_ready),
    .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid),
    .dr_data_ready(dr_data_ready),
    .dr_data(dr_data),
    .dw_data_addr_valid(dw_data_addr_valid),
    .dw_data_addr_ready(dw_data_addr_ready),
    .dw_addr(dw_addr),
    .dw_data(dw_data),
    .dw_strobe(dw_strobe),
    .dw_resp_valid(dw_resp_valid),
    .dw_resp_ready(dw_resp_ready),
    .dw_resp(dw_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed bytes, then sign/zero extend.
  function automatic logic [31:0] ref_load(input logic [31:0] d,
      input logic [31:0] a, input int sz, input bit uns);
    int n = 1 << sz;
    int lane = int'(a % 4);
    longint r = 0;
    for (int i = 0; i < n; i++)
      r = r + (longint'(d[8*(lane+i) +: 8]) << (8*i));
    if (!uns && r >= (longint'(1) << (8*n - 1)))
      r = r - (longint'(1) << (8*n));
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] w, input int sz);
    int n = 1 << sz;
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a, input int sz);
    int n = 1 << sz;
    int lane = int'(a % 4);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= lane) && (i < lane + n);
    return r;
  endfunction

  task automatic run(input bit st, input int sz, input bit uns,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
      input int w1, input int w2, input logic [1:0] resp);
    int cyc;
    bit mis;
    logic [1:0] eerr;
    logic [31:0] erd;
    mis = (sz == 3) || (a % (1 << sz) != 0);
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_store = st;
    req_size = 2'(sz);
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    cyc = 1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    if (mis) begin
      eerr = 2'd2;
      erd = '0;
      chk("mis_no_rd", dr_addr_valid, 0);
      chk("mis_no_wr", dw_data_addr_valid, 0);
    end else if (!st) begin
      for (int i = 0; i <= w1; i++) begin
        chk("rd_avalid", dr_addr_valid, 1);
        chk("rd_addr", dr_addr, a & ~32'h3);
        chk("rd_nodone", done_valid, 0);
        dr_addr_ready = (i == w1);
        @(negedge clk);
        cyc++;
      end
      dr_addr_ready = 1'b0;
      for (int i = 0; i <= w2; i++) begin
        chk("rd_dready", dr_data_ready, 1);
        chk("rd_avlow", dr_addr_valid, 0);
        dr_data_valid = (i == w2);
        dr_data = (i == w2) ? rd : $urandom;
        @(negedge clk);
        cyc++;
      end
      dr_data_valid = 1'b0;
      eerr = 2'd0;
      erd = ref_load(rd, a, sz, uns);
    end else begin
      for (int i = 0; i <= w1; i++) begin
        chk("wr_valid", dw_data_addr_valid, 1);
        chk("wr_addr", dw_addr, a & ~32'h3);
        chk("wr_data", dw_data, ref_wdata(wd, sz));
        chk("wr_strobe", dw_strobe, ref_strb(a, sz));
        dw_data_addr_ready = (i == w1);
        @(negedge clk);
        cyc++;
      end
      dw_data_addr_ready = 1'b0;
      for (int i = 0; i <= w2; i++) begin
        chk("wr_rready", dw_resp_ready, 1);
        chk("wr_vlow", dw_data_addr_valid, 0);
        dw_resp_valid = (i == w2);
        dw_resp = (i == w2) ? resp : 2'($urandom);
        @(negedge clk);
        cyc++;
      end
      dw_resp_valid = 1'b0;
      eerr = (resp == 2'd0) ? 2'd0 : 2'd1;
      erd = '0;
    end
    chk("latency", cyc, mis ? 1 : 3 + w1 + w2);
    chk("done_valid", done_valid, 1);
    chk("done_err", done_err, eerr);
    chk("done_rdata", done_rdata, erd);
    @(negedge clk);
    chk("done_pulse", done_valid, 0);
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valids", {dr_addr_valid, dr_data_ready, dw_data_addr_valid,
                       dw_resp_ready, done_valid}, 0);
    chk("rst_done", {done_err, done_rdata}, 0);
    chk("rst_addr", {dr_addr, dw_addr}, 0);
    chk("rst_wdata", {dw_data, dw_strobe}, 0);
    rst = 1'b1;

    run(0, 2, 0, 32'h104, '0, 32'hDEADBEEF, 0, 0, 2'd0);
    run(0, 0, 0, 32'h103, '0, 32'h80FF0000, 0, 0, 2'd0);
    run(0, 0, 1, 32'h103, '0, 32'h80FF0000, 0, 0, 2'd0);
    run(1, 1, 0, 32'h22, 32'h1234ABCD, '0, 0, 0, 2'd0);
    run(1, 1, 0, 32'h22, 32'h1234ABCD, '0, 0, 0, 2'd1);
    run(0, 2, 0, 32'h102, '0, 32'h11111111, 0, 0, 2'd0);
    run(0, 3, 0, 32'h100, '0, 32'h11111111, 0, 0, 2'd0);
    run(0, 1, 0, 32'h202, '0, 32'h8001_7FFF, 1, 2, 2'd0);
`ifdef LSU_TIMEOUT_EN
    run(0, 2, 0, 32'h104, '0, 32'hCAFEF00D, 3, 3, 2'd0);
    begin : timeout_step
      int cyc;
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b0;
      req_size = 2'd2;
      req_addr = 32'h300;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!done_valid && cyc < 20) begin
        chk("to_avalid", dr_addr_valid, 1);
        @(negedge clk);
        cyc++;
      end
      chk("to_latency", cyc, TO + 1);
      chk("to_err", done_err, 3);
      chk("to_rdata", done_rdata, 0);
      chk("to_novalid", dr_addr_valid, 0);
      @(negedge clk);
      chk("to_ready", req_ready, 1);
    end
`else
    run(0, 2, 0, 32'h104, '0, 32'hCAFEF00D, 5, 0, 2'd0);
`endif

    // reset while waiting for a write response
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size = 2'd2;
    req_addr = 32'h40;
    req_wdata = 32'h5A5A_0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    dw_data_addr_ready = 1'b1;
    @(negedge clk);
    dw_data_addr_ready = 1'b0;
    chk("rr_in_resp", dw_resp_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_valids", {dr_addr_valid, dr_data_ready, dw_data_addr_valid,
                      dw_resp_ready, done_valid}, 0);
    chk("rr_done", {done_err, done_rdata}, 0);
    chk("rr_addr", {dr_addr, dw_addr}, 0);
    chk("rr_wdata", {dw_data, dw_strobe}, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_nodone", done_valid, 0);
      chk("rr_ready", req_ready, 1);
    end

    for (int k = 0; k < 60; k++) begin
      int sz;
      logic [31:0] a;
      logic [1:0] rs;
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 1);
      rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
          int'($urandom_range(0, MAXW)), int'($urandom_range(0, MAXW)), rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/copperv_lsu.md
# copperv_lsu

Parametrised load/store unit for the copperv core. It owns the data read (`dr_*`) and data write (`dw_*`) bus channels and replaces the fixed word-only store path in the core top. It adds:
- byte, half and word accesses with byte-lane strobes and sign/zero extension;
- misalignment detection;
- a single-transaction FSM with a uniform completion/error report to the control unit.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; legal values are 32 or 64.
- ADDR_WIDTH, 32, address width in bits.
- RESP_WIDTH, 2, width of `dw_resp`. Value `DATA_WRITE_RESP_OK` means success; any other value means fail.
- TIMEOUT_CYCLES, 64, wait-state limit. Used only with `LSU_TIMEOUT_EN`.

Ports (S = DATA_WIDTH/8):
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  core requests an access.
- req_ready  out  1  LSU can accept a request; equals (state==IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword only when DATA_WIDTH=64; otherwise misaligned error).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- done_valid  out  1  single-cycle completion pulse.
- done_err  out  2  0 = ok, 1 = bus fail, 2 = misaligned, 3 = timeout.
- done_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for errors.
- dr_addr_valid / dr_addr_ready  out / in  1  read address handshake.
- dr_addr  out  ADDR_WIDTH  read address, aligned down to S bytes.
- dr_data_valid / dr_data_ready  in / out  1  read data handshake.
- dr_data  in  DATA_WIDTH  read data.
- dw_data_addr_valid / dw_data_addr_ready  out / in  1  write handshake.
- dw_addr  out  ADDR_WIDTH  write address, aligned down to S bytes.
- dw_data  out  DATA_WIDTH  write data, replicated across lanes.
- dw_strobe  out  S  byte-lane enables.
- dw_resp_valid / dw_resp_ready  in / out  1  write response handshake.
- dw_resp  in  RESP_WIDTH  write response code.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Accept condition: in IDLE, `req_valid` high (so `req_ready && req_valid`). On accept, register addr, size, unsigned and wdata.
- Alignment check: the access is misaligned if `req_addr mod 2^size != 0`, or if size=3 with DATA_WIDTH=32.
  - Misaligned request: go to DONE with err=2. No bus activity.
  - Aligned load: go to RD_ADDR.
  - Aligned store: go to WR_REQ.
- RD_ADDR: `dr_addr_valid`=1 and `dr_addr` held stable until `dr_addr_ready`; then go to RD_DATA.
- RD_DATA: `dr_data_ready`=1. On `dr_data_valid`, compute:
  - lane = addr mod S;
  - data = dr_data >> (8·lane), truncated to 2^size bytes, then extended per `req_unsigned`.
  - Go to DONE with err=0.
- WR_REQ: `dw_data_addr_valid`=1 until `dw_data_addr_ready`; then go to WR_RESP.
  - `dw_data` = low 2^size bytes of wdata, replicated to fill DATA_WIDTH.
  - `dw_strobe` = ((1<<2^size)−1) << lane.
- WR_RESP: `dw_resp_ready`=1. On `dw_resp_valid`, go to DONE with err = (resp==OK ? 0 : 1).
- DONE: `done_valid`=1 for exactly one cycle with registered err/rdata; then go to IDLE.
- Bus outputs are registered from state. Valids never drop before their ready is seen, except on timeout or reset.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE; all valids, `dr_data_ready`, `dw_resp_ready`, `done_valid`, `done_err`, `done_rdata`, addresses, `dw_data` and `dw_strobe` are 0. `req_ready` reads 1 from the first cycle after reset.
- Reset mid-transaction aborts the transaction. Valids drop at that edge and no `done_valid` is produced.
- Load latency with zero-wait bus (accept at cycle 0):
  - `dr_addr_valid` high in cycle 1;
  - `dr_data_ready` high in cycle 2;
  - `done_valid` high in cycle 3.
- Store latency is the same: `dw_data_addr_valid` in cycle 1, `dw_resp_ready` in cycle 2, `done_valid` in cycle 3.
- Misaligned request: `done_valid` in cycle 1.
- Throughput: the next request is accepted in the cycle after DONE. Maximum rate is one access per 4 cycles.
- A response arriving in the same cycle a ready is first raised counts as a handshake.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to each wait state (RD_ADDR, RD_DATA, WR_REQ, WR_RESP) and increments every cycle spent there.
  - When the count reaches TIMEOUT_CYCLES−1 with no handshake, the FSM drops valid/ready, goes to DONE with err=3, and returns to IDLE.
  - A handshake in that same cycle wins and completes normally.
- `LSU_TIMEOUT_EN` undefined: no counter is built, err=3 never occurs, and wait states are unbounded.

## Test plan
- Load word, zero-wait bus: addr 0x104, `dr_data`=0xDEADBEEF -> `dr_addr`=0x104, `done_valid` at cycle 3, rdata=0xDEADBEEF, err=0.
- Signed byte load: addr 0x103, data 0x80FF0000 -> rdata=0xFFFFFF80. Same access with `req_unsigned`=1 -> rdata=0x00000080.
- Half store: addr 0x22, wdata 0x1234ABCD -> `dw_addr`=0x20, `dw_data`=0xABCDABCD, `dw_strobe`=4'b1100. `dw_resp`=OK -> err=0; `dw_resp`=FAIL -> err=1.
- Misaligned word load at 0x102 -> `done_valid` at cycle 1 with err=2; no `dr_addr_valid` ever asserted.
- `dr_addr_ready` held low for 5 cycles -> `dr_addr` stable and valid high throughout; completion arrives 5 cycles later. With `LSU_TIMEOUT_EN` and TIMEOUT_CYCLES=4 -> err=3 after 4 wait cycles.
- `rst`=0 while in WR_RESP -> all outputs 0 next cycle, no done pulse, `req_ready`=1 after reset releases.
